// File: rtl/nios2_proc_debug_host_pkg.sv
// Shared types and constants for the Nios II debug host sequencer.
// Consumers: nios2_proc_nios2_cpu_debug_host_seq and nios2_proc_debug_host_tck_gen.
package nios2_proc_debug_host_pkg;

  localparam int DR_W_DEF = 38;
  localparam int IR_W_DEF = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RESP
  } state_t;

  // Strobe vector ordered {uir, cdr, sdr, udr, rti}; exactly one bit per shifting phase.
  function automatic logic [4:0] strobes_for(state_t s);
    case (s)
      UIR:     return 5'b10000;
      CDR:     return 5'b01000;
      SDR:     return 5'b00100;
      UDR:     return 5'b00010;
      RTI:     return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/nios2_proc_debug_host_tck_gen.sv
// tck divider: toggles tck every TCK_DIV clk cycles while enabled, and flags the
// clk cycle on which tck rises or falls so the sequencer acts on those edges.
module nios2_proc_debug_host_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(TCK_DIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nios2_proc_nios2_cpu_debug_host_seq.sv
// On-chip virtual-JTAG initiator: runs one IR/DR command through UIR-CDR-SDR-UDR-RTI.
// Optional macro NIOS2_DEBUG_HOST_IR_CACHE_EN skips UIR when the IR is unchanged.
module nios2_proc_nios2_cpu_debug_host_seq
  import nios2_proc_debug_host_pkg::*;
#(
  parameter int TCK_DIV    = 2,
  parameter int DR_W       = DR_W_DEF,
  parameter int IR_W       = IR_W_DEF,
  parameter int RTI_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic [IR_W-1:0] rsp_ir_out,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int SW = $clog2(DR_W + 1);
  localparam int RW = $clog2(RTI_CYCLES + 1);

  state_t          state;
  logic [DR_W-1:0] sr;
  logic [SW-1:0]   shift_cnt;
  logic [RW-1:0]   rti_cnt;
  logic            tck_en;
  logic            tck_rise;
  logic            tck_fall;

`ifdef NIOS2_DEBUG_HOST_IR_CACHE_EN
  logic [IR_W-1:0] ir_cache;
  logic            ir_cache_valid;
  logic            ir_hit;
  assign ir_hit = ir_cache_valid && (ir_cache == cmd_ir);
`endif

  assign tck_en = (state != IDLE) && (state != RESP);

  nios2_proc_debug_host_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tck_en),
    .tck     (vji_tck),
    .rise    (tck_rise),
    .fall    (tck_fall)
  );

  // Phases advance on tck falling edges; tdo and ir_out are taken on rising edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      sr         <= '0;
      shift_cnt  <= '0;
      rti_cnt    <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= '0;
`ifdef NIOS2_DEBUG_HOST_IR_CACHE_EN
      ir_cache       <= '0;
      ir_cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            sr        <= cmd_dr;
            cmd_ready <= 1'b0;
`ifdef NIOS2_DEBUG_HOST_IR_CACHE_EN
            ir_cache       <= cmd_ir;
            ir_cache_valid <= 1'b1;
            if (ir_hit) begin
              state <= CDR;
              {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(CDR);
            end else begin
              state     <= UIR;
              vji_ir_in <= cmd_ir;
              {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(UIR);
            end
`else
            state     <= UIR;
            vji_ir_in <= cmd_ir;
            {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(UIR);
`endif
          end
        end
        UIR: begin
          if (tck_fall) begin
            state <= CDR;
            {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(CDR);
          end
        end
        CDR: begin
          if (tck_fall) begin
            state     <= SDR;
            shift_cnt <= SW'(DR_W);
            vji_tdi   <= sr[0];
            {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(SDR);
          end
        end
        SDR: begin
          if (tck_rise) begin
            sr        <= {vji_tdo, sr[DR_W-1:1]};
            shift_cnt <= shift_cnt - SW'(1);
          end else if (tck_fall) begin
            if (shift_cnt == '0) begin
              state   <= UDR;
              vji_tdi <= 1'b0;
              {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(UDR);
            end else begin
              vji_tdi <= sr[0];
            end
          end
        end
        UDR: begin
          if (tck_rise) begin
            rsp_ir_out <= vji_ir_out;
          end else if (tck_fall) begin
            state   <= RTI;
            rti_cnt <= RW'(RTI_CYCLES);
            {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(RTI);
          end
        end
        RTI: begin
          if (tck_fall) begin
            if (rti_cnt == RW'(1)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_dr    <= sr;
              {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strobes_for(RESP);
            end else begin
              rti_cnt <= rti_cnt - RW'(1);
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_proc_nios2_cpu_debug_host_seq.sv
// Self-checking bench for nios2_proc_nios2_cpu_debug_host_seq with a virtual-JTAG slave model.
// Expected responses are queued at command acceptance and checked when rsp_valid rises.
module tb_nios2_proc_nios2_cpu_debug_host_seq;

  localparam int DR_W = 38;
  localparam int IR_W = 2;
  localparam int BOUND = 1000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_dr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DR_W-1:0] rsp_dr;
  logic [IR_W-1:0] rsp_ir_out;
  logic            vji_tck;
  logic            vji_tdi;
  logic            vji_tdo;
  logic [IR_W-1:0] vji_ir_in;
  logic [IR_W-1:0] vji_ir_out;
  logic            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr_rx;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] ir_out;
    int              lat;
    bit              uir;
  } exp_t;

  exp_t sb[$];

  nios2_proc_nios2_cpu_debug_host_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_dr     (cmd_dr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dr     (rsp_dr),
    .rsp_ir_out (rsp_ir_out),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (vji_ir_out),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: captures on cdr, shifts LSB-first on tck rise, latches received DR on udr.
  logic [DR_W-1:0] cap_val = '0;
  logic [IR_W-1:0] ir_out_val = '0;
  logic [DR_W-1:0] slave_sr = '0;
  logic [DR_W-1:0] slave_rx = '0;
  int              strobe_log[$];
  int              sdr_rises = 0;

  assign vji_tdo    = slave_sr[0];
  assign vji_ir_out = vji_udr ? ir_out_val : '0;

  always @(posedge vji_tck) begin
    if (vji_cdr) slave_sr <= cap_val;
    else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[DR_W-1:1]};
    if (vji_udr) slave_rx <= slave_sr;
    if (vji_sdr) sdr_rises <= sdr_rises + 1;
    strobe_log.push_back(int'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}));
  end

  // Reference IR cache, mirrors the optional skip-UIR behaviour at the command level.
  logic [IR_W-1:0] model_ir = '0;
  bit              model_ir_valid = 1'b0;
  int              accept_cyc = 0;

  function automatic bit log_matches(bit with_uir);
    int exp_log[$];
    if (with_uir) exp_log.push_back(16);
    exp_log.push_back(8);
    for (int i = 0; i < DR_W; i++) exp_log.push_back(4);
    exp_log.push_back(2);
    for (int i = 0; i < 4; i++) exp_log.push_back(1);
    if (exp_log.size() != strobe_log.size()) return 1'b0;
    foreach (exp_log[i]) if (exp_log[i] != strobe_log[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                          input logic [DR_W-1:0] cap, input logic [IR_W-1:0] iro,
                          output int waited);
    exp_t e;
    bit   hit;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_dr    = dr;
    waited    = 0;
    while (!cmd_ready && waited < BOUND) begin
      @(negedge clk);
      waited++;
    end
`ifdef NIOS2_DEBUG_HOST_IR_CACHE_EN
    hit = model_ir_valid && (model_ir == ir);
`else
    hit = 1'b0;
`endif
    model_ir       = ir;
    model_ir_valid = 1'b1;
    cap_val    = cap;
    ir_out_val = iro;
    e.ir     = ir;
    e.dr_rx  = dr;
    e.rsp_dr = cap;
    e.ir_out = iro;
    e.lat    = hit ? 176 : 180;
    e.uir    = !hit;
    sb.push_back(e);
    strobe_log.delete();
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
    cmd_ir     = IR_W'($urandom);
    cmd_dr     = DR_W'({$urandom, $urandom});
  endtask

  task automatic get_rsp(output bit timed_out, output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < BOUND);
    timed_out = !rsp_valid;
    lat = cyc - accept_cyc;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_ir    = '0;
    cmd_dr    = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      obs = 64'({vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
                 cmd_ready, rsp_valid, rsp_ir_out, rsp_dr});
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h, want 0", i, obs);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_ir_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: got %b, want 1", cmd_ready);
    end
  endtask

  task automatic test_single_command();
    exp_t e;
    bit   to;
    int   lat, waited;
    send_cmd(2'b00, 38'h15_A5A5A5A5, 38'h2A_5A5A5A5A, 2'b10, waited);
    get_rsp(to, lat);
    e = sb.pop_front();
    checks++;
    if (to) begin
      failures++;
      $display("[TB] FAIL single_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, BOUND);
    end
    checks++;
    if (rsp_dr !== e.rsp_dr) begin
      failures++;
      $display("[TB] FAIL single_rsp_dr: got %h, want %h", rsp_dr, e.rsp_dr);
    end
    checks++;
    if (slave_rx !== e.dr_rx) begin
      failures++;
      $display("[TB] FAIL single_slave_rx: got %h, want %h", slave_rx, e.dr_rx);
    end
    checks++;
    if (lat != e.lat) begin
      failures++;
      $display("[TB] FAIL single_latency: got %0d, want %0d", lat, e.lat);
    end
    checks++;
    if (rsp_ir_out !== e.ir_out) begin
      failures++;
      $display("[TB] FAIL single_ir_out: got %b, want %b", rsp_ir_out, e.ir_out);
    end
    checks++;
    if (!log_matches(e.uir)) begin
      failures++;
      $display("[TB] FAIL single_strobe_order: got %0d tck periods, want %0d", strobe_log.size(), e.uir ? 45 : 44);
    end
    checks++;
    if (vji_ir_in !== e.ir || vji_tck !== 1'b0 || vji_tdi !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_idle_pins: got ir_in=%b tck=%b tdi=%b, want %b 0 0", vji_ir_in, vji_tck, vji_tdi, e.ir);
    end
    release_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_handshake: got rsp_valid=%b cmd_ready=%b, want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_backpressure();
    exp_t            e;
    bit              to, unstable;
    int              lat, waited;
    logic [DR_W-1:0] dr2;
    logic [DR_W-1:0] held_dr;
    logic [IR_W-1:0] held_iro;
    send_cmd(2'b01, DR_W'({$urandom, $urandom}), DR_W'({$urandom, $urandom}), 2'b01, waited);
    get_rsp(to, lat);
    e = sb.pop_front();
    checks++;
    if (to || rsp_dr !== e.rsp_dr || lat != e.lat) begin
      failures++;
      $display("[TB] FAIL bp_first_rsp: got dr=%h lat=%0d, want dr=%h lat=%0d", rsp_dr, lat, e.rsp_dr, e.lat);
    end
    held_dr  = rsp_dr;
    held_iro = rsp_ir_out;
    dr2      = DR_W'({$urandom, $urandom});
    cmd_valid = 1'b1;
    cmd_ir    = 2'b11;
    cmd_dr    = dr2;
    unstable  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dr !== held_dr || rsp_ir_out !== held_iro || cmd_ready !== 1'b0)
        unstable = 1'b1;
    end
    checks++;
    if (unstable) begin
      failures++;
      $display("[TB] FAIL bp_hold: got rsp_valid=%b dr=%h iro=%b ready=%b, want 1 %h %b 0",
               rsp_valid, rsp_dr, rsp_ir_out, cmd_ready, held_dr, held_iro);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    send_cmd(2'b11, dr2, 38'h3F_0F0F0F0F, 2'b11, waited);
    checks++;
    if (waited != 0) begin
      failures++;
      $display("[TB] FAIL bp_next_accept: got wait %0d cycles, want 0", waited);
    end
    get_rsp(to, lat);
    e = sb.pop_front();
    checks++;
    if (to || rsp_dr !== e.rsp_dr || slave_rx !== e.dr_rx || rsp_ir_out !== e.ir_out || lat != e.lat) begin
      failures++;
      $display("[TB] FAIL bp_second_rsp: got dr=%h rx=%h iro=%b lat=%0d, want %h %h %b %0d",
               rsp_dr, slave_rx, rsp_ir_out, lat, e.rsp_dr, e.dr_rx, e.ir_out, e.lat);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid_sdr();
    exp_t e;
    bit   to, rose;
    int   lat, waited, n;
    send_cmd(2'b10, 38'h00_DEADBEEF, 38'h11_22334455, 2'b10, waited);
    sdr_rises = 0;
    n = 0;
    while (sdr_rises < 10 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sdr_rises < 10) begin
      failures++;
      $display("[TB] FAIL mid_sdr_reach: got %0d shifts, want 10", sdr_rises);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (vji_sdr !== 1'b0 || vji_tck !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_sdr_reset: got sdr=%b tck=%b rsp_valid=%b ready=%b, want 0 0 0 0",
               vji_sdr, vji_tck, rsp_valid, cmd_ready);
    end
    void'(sb.pop_back());
    model_ir_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_sdr_idle: got cmd_ready=%b, want 1", cmd_ready);
    end
    rose = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      failures++;
      $display("[TB] FAIL mid_sdr_no_rsp: got rsp_valid=1, want 0");
    end
    send_cmd(2'b10, 38'h2B_CAFEF00D, 38'h05_5AA55AA5, 2'b01, waited);
    get_rsp(to, lat);
    e = sb.pop_front();
    checks++;
    if (to || rsp_dr !== e.rsp_dr || slave_rx !== e.dr_rx || rsp_ir_out !== e.ir_out || lat != e.lat
        || !log_matches(e.uir)) begin
      failures++;
      $display("[TB] FAIL mid_sdr_fresh: got dr=%h rx=%h iro=%b lat=%0d, want %h %h %b %0d",
               rsp_dr, slave_rx, rsp_ir_out, lat, e.rsp_dr, e.dr_rx, e.ir_out, e.lat);
    end
    release_rsp();
  endtask

  task automatic test_ir_cache();
    logic [IR_W-1:0] irs[4] = '{2'b00, 2'b10, 2'b10, 2'b11};
    exp_t            e;
    bit              to;
    int              lat, waited;
    for (int i = 0; i < 4; i++) begin
      send_cmd(irs[i], DR_W'({$urandom, $urandom}), DR_W'({$urandom, $urandom}), 2'b10, waited);
      get_rsp(to, lat);
      e = sb.pop_front();
      checks++;
      if (to || lat != e.lat || !log_matches(e.uir)) begin
        failures++;
        $display("[TB] FAIL ir_cache_cmd%0d: got lat=%0d periods=%0d, want lat=%0d periods=%0d",
                 i, lat, strobe_log.size(), e.lat, e.uir ? 45 : 44);
      end
      checks++;
      if (rsp_dr !== e.rsp_dr || slave_rx !== e.dr_rx || vji_ir_in !== e.ir || rsp_ir_out !== e.ir_out) begin
        failures++;
        $display("[TB] FAIL ir_cache_data%0d: got dr=%h rx=%h ir_in=%b iro=%b, want %h %h %b %b",
                 i, rsp_dr, slave_rx, vji_ir_in, rsp_ir_out, e.rsp_dr, e.dr_rx, e.ir, e.ir_out);
      end
      release_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_single_command();
    test_backpressure();
    test_reset_mid_sdr();
    test_ir_cache();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios2_proc_nios2_cpu_debug_host_seq.md
Name: nios2_proc_nios2_cpu_debug_host_seq

Overview:
- On-chip initiator for the Nios II debug slave's virtual-JTAG interface. It takes one debug command at a time: a 2-bit IR plus a 38-bit DR.
- Per command it generates tck, drives the virtual-state strobes (uir, cdr, sdr, udr, rti), shifts the DR out on tdi and captures tdo.
- Used in the sim/self-test build, where the virtual-JTAG pins are otherwise tied off, and for a future on-chip debug master in place of the host cable.

Parameters:
- TCK_DIV, 2, clk cycles per tck half-period (min 1).
- DR_W, 38, data-register shift length.
- IR_W, 2, instruction-register width.
- RTI_CYCLES, 4, tck periods held in run-test-idle after udr so the sysclk-side synchronizer sees the update (min 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_ir  in  IR_W  instruction to load
- cmd_dr  in  DR_W  data to shift in, LSB first
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dr  out  DR_W  data captured from tdo
- rsp_ir_out  out  IR_W  vji_ir_out sampled at the udr phase
- vji_tck  out  1  generated tck
- vji_tdi  out  1  serial data out
- vji_tdo  in  1  serial data in
- vji_ir_in  out  IR_W  instruction presented to the slave
- vji_ir_out  in  IR_W  slave status
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state strobes

Behaviour:
- Reset (reset_n=0 at a clk edge), including mid-command:
  - state IDLE, tck counter 0, vji_tck=0
  - all strobes 0, vji_tdi=0, vji_ir_in=0
  - cmd_ready=0 during reset, 1 on the first cycle after reset
  - rsp_valid=0, rsp_dr=0, rsp_ir_out=0
  - IR cache invalid (when the Optional Feature is enabled)
  - Any in-flight command is discarded.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - On acceptance, cmd_ir and cmd_dr are latched; inputs are don't-care afterwards.
  - rsp_valid holds with stable rsp_dr and rsp_ir_out until rsp_ready.
  - cmd_ready returns to 1 on the cycle after the rsp handshake, so there is no same-cycle rsp/cmd overlap.
- tck generation:
  - vji_tck toggles every TCK_DIV clk cycles while not in IDLE or RESP; it is 0 in IDLE and RESP.
  - One tck period is 2*TCK_DIV clk cycles.
  - Phase transitions and tdi updates occur on the clk cycle of a tck falling edge.
  - tdo is sampled on the clk cycle of the tck rising edge.
- FSM, one strobe high per phase, held for the whole phase:
  - IDLE -> UIR on accept. UIR lasts 1 tck period; vji_ir_in=latched IR from UIR onward until the next UIR.
  - UIR -> CDR, 1 period.
  - CDR -> SDR, DR_W periods. tdi=sr[0]. On each rising edge, sr <= {tdo, sr[DR_W-1:1]}. After DR_W shifts, sr holds the captured data.
  - SDR -> UDR, 1 period. vji_ir_out is sampled into rsp_ir_out on the UDR rising edge.
  - UDR -> RTI, RTI_CYCLES periods.
  - RTI -> RESP: rsp_valid=1, rsp_dr=sr.
  - RESP -> IDLE on rsp_ready.
- Latency: rsp_valid rises exactly 2*TCK_DIV*(3+DR_W+RTI_CYCLES) clk cycles after the accept edge. Defaults give 4*45=180.
- A shift counter of width $clog2(DR_W+1) counts DR_W..1 and never wraps.
- vji_tdi=0 outside SDR.

Optional Feature:
- Macro: NIOS2_DEBUG_HOST_IR_CACHE_EN.
- Defined: the block keeps the last IR issued plus a valid bit. If the new cmd_ir equals the cached IR and the cache is valid, the UIR phase is skipped and the FSM goes IDLE -> CDR. Latency drops by one tck period (176 at defaults). The cache is invalidated by reset.
- Undefined: UIR is always issued.

Decomposition:
- Package nios2_proc_debug_host_pkg holds:
  - FSM state enum (IDLE, UIR, CDR, SDR, UDR, RTI, RESP)
  - IR code constants: IR_OCIMEM=2'b00, IR_TRACEMEM=2'b01, IR_BREAK=2'b10, IR_TRACECTRL=2'b11
  - default DR_W and IR_W
- Sub-module nios2_proc_debug_host_tck_gen: divider producing vji_tck plus one-cycle rise/fall enables; enabled by the FSM.

Test Plan:
- Reset check: hold reset_n=0 for 3 clk -> all outputs 0, vji_tck static 0. On release, cmd_ready=1 on the next clk.
- Single command: bench slave model captures 38'h2A_5A5A5A5A on cdr and shifts on the tck rising edge. Issue cmd_ir=2'b00, cmd_dr=38'h15_A5A5A5A5 -> model receives 38'h15_A5A5A5A5 at udr; rsp_dr=38'h2A_5A5A5A5A; rsp_valid at exactly clk 180; strobe order uir, cdr, sdr×38, udr, rti×4.
- Backpressure: rsp_ready=0 for 50 clk -> rsp_valid, rsp_dr and rsp_ir_out stable; cmd_ready=0 with cmd_valid held high; second command accepted on the cycle after rsp_ready=1.
- Reset mid-SDR: assert reset_n=0 after 10 shifts -> next clk is IDLE, vji_sdr=0, vji_tck=0, rsp_valid never rises; a fresh command afterwards completes normally.
- ir_out capture: model drives vji_ir_out=2'b10 only during udr -> rsp_ir_out=2'b10.
- IR cache, macro defined: two commands with cmd_ir=2'b10 -> second has no uir pulse and rsp_valid at clk 176. Third command with 2'b11 -> uir present, 180 clk.
